// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin share of one LANES-wide approximate compressor bank among NREQ requesters
// ports: req_valid/req_ready with packed p,q,r,s operands in; res_sum/res_carry/res_id registered out, res_valid/res_ready handshake
// COMP_ARB_STATS_EN adds stats_clr input and grant_cnt output (per-requester 16-bit accept counters)
module comp_arbiter #(
  parameter int NREQ = 4,
  parameter int LANES = 8,
  parameter int IDW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*LANES-1:0]  req_p,
  input  logic [NREQ*LANES-1:0]  req_q,
  input  logic [NREQ*LANES-1:0]  req_r,
  input  logic [NREQ*LANES-1:0]  req_s,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [LANES-1:0]       res_sum,
  output logic [LANES-1:0]       res_carry,
  output logic [IDW-1:0]         res_id
`ifdef COMP_ARB_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NREQ*16-1:0]     grant_cnt
`endif
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic res_valid_q, res_valid_d, acc;
  logic [LANES-1:0] sum_q, sum_d, carry_q, carry_d, p_w, q_w;
  logic [IDW-1:0] id_q, id_d;
  logic unused_rs;
  assign unused_rs = ^{req_r, req_s};
  // descending scan so the last overwrite is the first valid at or after ptr
  always_comb begin
    win = '0;
    for (int o = NREQ - 1; o >= 0; o--)
      if (req_valid[(int'(ptr_q) + o) % NREQ]) win = PW'((int'(ptr_q) + o) % NREQ);
  end
  always_comb begin
    acc = rst_n & (~res_valid_q | res_ready) & (|req_valid);
    req_ready = acc ? NREQ'(1) << win : '0;
    p_w = req_p[win*LANES +: LANES];
    q_w = req_q[win*LANES +: LANES];
    res_valid_d = acc | (res_valid_q & ~res_ready);
    sum_d = acc ? p_w & q_w : sum_q;
    carry_d = acc ? p_w | q_w : carry_q;
    id_d = acc ? IDW'(win) : id_q;
    ptr_d = acc ? (win == PW'(NREQ - 1) ? '0 : win + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      sum_q <= '0;
      carry_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
    end
  end
  assign res_valid = res_valid_q;
  assign res_sum = sum_q;
  assign res_carry = carry_q;
  assign res_id = id_q;
`ifdef COMP_ARB_STATS_EN
  logic [NREQ*16-1:0] cnt_q, cnt_d;
  // clear happens before the increment so a same-cycle accept lands on 1
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++)
      cnt_d[i*16 +: 16] = (stats_clr ? 16'h0 : cnt_q[i*16 +: 16]) + 16'(acc && win == PW'(i));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_comp_arbiter.sv
// tb_comp_arbiter: directed + random checks of comp_arbiter against a behavioural model
module tb_comp_arbiter;
  localparam int N = 4;
  localparam int L = 8;
  logic clk, rst_n, res_ready, res_valid, stats_clr;
  logic [N-1:0] req_valid, req_ready;
  logic [N*L-1:0] req_p, req_q, req_r, req_s;
  logic [L-1:0] res_sum, res_carry;
  logic [1:0] res_id;
`ifdef COMP_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif
  int vecs = 0, errs = 0;
  logic m_valid;
  logic [L-1:0] m_sum, m_carry;
  int m_id, m_ptr;
  logic [15:0] m_cnt[N];
  comp_arbiter #(.NREQ(N), .LANES(L), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .req_q(req_q), .req_r(req_r), .req_s(req_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_id(res_id)
`ifdef COMP_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int o = 0; o < N; o++)
      if (v[(ptr + o) % N]) return (ptr + o) % N;
    return -1;
  endfunction
  task automatic model_reset();
    m_valid = 0;
    m_sum = 0;
    m_carry = 0;
    m_id = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask
  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_p[i*L +: L] = L'($urandom);
      req_q[i*L +: L] = L'($urandom);
      req_r[i*L +: L] = L'($urandom);
      req_s[i*L +: L] = L'($urandom);
    end
  endtask
  task automatic cyc(input logic rn, input logic [N-1:0] v, input logic rr, input logic clr);
    int w;
    logic acc;
    rst_n = rn;
    req_valid = v;
    res_ready = rr;
    stats_clr = clr;
    #1;
    w = pick(v, m_ptr);
    acc = rn && (!m_valid || rr) && w >= 0;
    chk("req_ready", 32'(req_ready), acc ? 32'(1) << w : 32'(0));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_sum", 32'(res_sum), 32'(m_sum));
    chk("res_carry", 32'(res_carry), 32'(m_carry));
    chk("res_id", 32'(res_id), 32'(m_id));
`ifdef COMP_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("grant_cnt%0d", i), 32'(grant_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
    @(posedge clk);
    if (!rn) model_reset();
    else begin
      if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
      if (acc) begin
        m_valid = 1;
        m_sum = req_p[w*L +: L] & req_q[w*L +: L];
        m_carry = req_p[w*L +: L] | req_q[w*L +: L];
        m_id = w;
        m_ptr = (w + 1) % N;
        m_cnt[w] = m_cnt[w] + 16'd1;
      end else if (rr) m_valid = 0;
    end
    @(negedge clk);
  endtask
  initial begin
    rst_n = 0;
    req_valid = '1;
    res_ready = 1;
    stats_clr = 0;
    rand_ops();
    @(posedge clk);
    @(negedge clk);
    model_reset();
    cyc(0, '1, 1, 0);
    req_p = '0;
    req_q = '0;
    req_p[2*L +: L] = 8'hF0;
    req_q[2*L +: L] = 8'h3C;
    cyc(1, 4'b0100, 1, 0);
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_sum", 32'(res_sum), 32'h30);
    chk("single_carry", 32'(res_carry), 32'hFC);
    chk("single_id", 32'(res_id), 32'd2);
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      cyc(1, '1, 1, 0);
      chk("rr_order", 32'(res_id), 32'(i % N));
    end
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cyc(1, '1, 0, 0);
      chk("bp_id", 32'(res_id), 32'd3);
    end
    cyc(1, '1, 1, 0);
    chk("bp_release_id", 32'(res_id), 32'd0);
    chk("bp_release_valid", 32'(res_valid), 32'd1);
    cyc(0, 4'b1010, 1, 0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    cyc(1, 4'b1010, 1, 0);
    chk("mid_rst_id", 32'(res_id), 32'd1);
`ifdef COMP_ARB_STATS_EN
    cyc(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 4'b1000, 1, 0);
    chk("cnt3_before_clr", 32'(grant_cnt[3*16 +: 16]), 32'd5);
    cyc(1, 4'b1000, 1, 1);
    chk("cnt3_after_clr", 32'(grant_cnt[3*16 +: 16]), 32'd1);
`endif
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      cyc($urandom_range(0, 49) != 0, N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
